rr_request_arbiter: RTL and testbench

Round-robin arbiter that sits directly downstream of several fifo_queue instances. It drains their request_out/request_valid_out/issue_ack_in interfaces into one output stream, and that stream uses the same valid/ack handshake. Each accepted entry is held in a one-entry output buffer, so output valid never depends combinationally on upstream valid. Typical use is merging per-source request queues into one shared port (memory, bus or network).

---
 rtl/rr_request_arbiter_if.sv | 51 +++++
 rtl/rr_request_arbiter.sv | 117 +++++++++++
 tb/tb_rr_request_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rr_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_request_arbiter_if
// Bundles the upstream FIFO-facing signals and the downstream valid/ack
// stream of the round-robin request arbiter.
//
// Signals:
//   request_flatted_in        N*W   entry slices from the upstream FIFOs
//   request_valid_flatted_in  N     per-FIFO valid
//   issue_ack_out             N     per-FIFO one-cycle capture pulse
//   request_out               W     buffered entry
//   request_valid_out         1     buffer holds a valid entry
//   grant_id_out              LOG2  source index of the buffered entry
//   issue_ack_in              1     downstream accept pulse
//
// Modports:
//   slave  - arbiter side
//   master - side that drives the FIFO data and consumes the output stream
// ---------------------------------------------------------------------------
interface rr_request_arbiter_if #(
    parameter int NUM_REQUESTERS             = 4,
    parameter int NUM_REQUESTERS_LOG2        = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
);
    logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_flatted_in;
    logic [NUM_REQUESTERS-1:0]                            request_valid_flatted_in;
    logic [NUM_REQUESTERS-1:0]                            issue_ack_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                request_out;
    logic                                                 request_valid_out;
    logic [NUM_REQUESTERS_LOG2-1:0]                       grant_id_out;
    logic                                                 issue_ack_in;

    modport slave (
        input  request_flatted_in,
        input  request_valid_flatted_in,
        output issue_ack_out,
        output request_out,
        output request_valid_out,
        output grant_id_out,
        input  issue_ack_in
    );

    modport master (
        output request_flatted_in,
        output request_valid_flatted_in,
        input  issue_ack_out,
        input  request_out,
        input  request_valid_out,
        input  grant_id_out,
        output issue_ack_in
    );
endinterface

// File: rtl/rr_request_arbiter.sv
// ---------------------------------------------------------------------------
// rr_request_arbiter
// Round-robin arbiter that drains several upstream FIFOs into a single
// valid/ack output stream through a one-entry output buffer, so the output
// valid is always a register and never follows upstream valid directly.
//
// Ports:
//   clk_in    - single clock, all state updates on posedge
//   reset_in  - synchronous, active-high reset
//   arb_bus   - rr_request_arbiter_if.slave: FIFO entries/valids in,
//               per-FIFO ack pulses out, buffered entry/valid/grant id out,
//               downstream ack in
// ---------------------------------------------------------------------------
module rr_request_arbiter #(
    parameter int NUM_REQUESTERS             = 4,
    parameter int NUM_REQUESTERS_LOG2        = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
) (
    input logic                 clk_in,
    input logic                 reset_in,
    rr_request_arbiter_if.slave arb_bus
);
    localparam int N = NUM_REQUESTERS;
    localparam int L = NUM_REQUESTERS_LOG2;
    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   request_q, request_d;
    logic [L-1:0]   grant_id_q, grant_id_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [L-1:0]   last_grant_q, last_grant_d;

    logic [N-1:0]   eligible;
    logic           grant_found;
    logic [L-1:0]   grant_idx;
    logic [L-1:0]   candidate;
    logic           capture;

    // A source acked last cycle still shows its old entry this cycle, so it
    // is masked for one cycle to avoid capturing the same entry twice.
    assign eligible = arb_bus.request_valid_flatted_in & ~ack_q;

    // Scan from last_grant+1 upward; the L-bit add wraps naturally, and the
    // final step (k = N) revisits last_grant itself as lowest priority.
    always_comb begin : grant_select
        grant_found = 1'b0;
        grant_idx   = '0;
        candidate   = '0;
        for (int k = 1; k <= N; k++) begin
            candidate = last_grant_q + L'(k);
            if (!grant_found && eligible[candidate]) begin
                grant_found = 1'b1;
                grant_idx   = candidate;
            end
        end
    end

    // The buffer can take a new entry when empty, or when full and being
    // drained downstream in the same cycle (back-to-back).
    always_comb begin : next_state_logic
        state_d      = state_q;
        request_d    = request_q;
        grant_id_d   = grant_id_q;
        ack_d        = '0;
        last_grant_d = last_grant_q;
        capture      = 1'b0;

        case (state_q)
            EMPTY: begin
                capture = grant_found;
            end
            FULL: begin
                if (arb_bus.issue_ack_in) begin
                    capture = grant_found;
                    if (!grant_found) begin
                        state_d = EMPTY;
                    end
                end
            end
        endcase

        if (capture) begin
            state_d          = FULL;
            request_d        = arb_bus.request_flatted_in[W*int'(grant_idx) +: W];
            grant_id_d       = grant_idx;
            ack_d[grant_idx] = 1'b1;
            last_grant_d     = grant_idx;
        end
    end

    // Pointer resets to N-1 so that requester 0 wins the first arbitration.
    always_ff @(posedge clk_in) begin : state_register
        if (reset_in) begin
            state_q      <= EMPTY;
            request_q    <= '0;
            grant_id_q   <= '0;
            ack_q        <= '0;
            last_grant_q <= L'(N - 1);
        end else begin
            state_q      <= state_d;
            request_q    <= request_d;
            grant_id_q   <= grant_id_d;
            ack_q        <= ack_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign arb_bus.request_out       = request_q;
    assign arb_bus.request_valid_out = (state_q == FULL);
    assign arb_bus.grant_id_out      = grant_id_q;
    assign arb_bus.issue_ack_out     = ack_q;
endmodule

// File: tb/tb_rr_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_request_arbiter
// Directed, table-driven bench for rr_request_arbiter (4 requesters, 64-bit
// entries). Each vector drives one cycle of upstream valids and downstream
// ack, then compares the registered outputs just after the clock edge
// against hand-computed expectations. Hand-written sequences cover reset,
// a single source with changing data, and reset during a stalled entry.
// ---------------------------------------------------------------------------
module tb_rr_request_arbiter;
    localparam int N    = 4;
    localparam int L    = 2;
    localparam int W    = 64;

    typedef struct {
        logic [N-1:0] valid;
        logic         ack_in;
        logic         exp_valid;
        logic [L-1:0] exp_grant;
        logic [N-1:0] exp_ack;
    } vec_t;

    logic         clk_in;
    logic         reset_in;
    logic [W-1:0] srcData [N];
    vec_t         vecs [$];
    int           vectorsApplied;
    int           miscompares;

    rr_request_arbiter_if #(
        .NUM_REQUESTERS            (N),
        .NUM_REQUESTERS_LOG2       (L),
        .SINGLE_ENTRY_WIDTH_IN_BITS(W)
    ) arb_bus ();

    rr_request_arbiter #(
        .NUM_REQUESTERS            (N),
        .NUM_REQUESTERS_LOG2       (L),
        .SINGLE_ENTRY_WIDTH_IN_BITS(W)
    ) dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .arb_bus (arb_bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Drive one cycle of inputs on the falling edge, then let the rising
    // edge happen and settle just after it.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic ack_in, input logic rst);
        @(negedge clk_in);
        reset_in                         = rst;
        arb_bus.request_valid_flatted_in = valid;
        arb_bus.issue_ack_in             = ack_in;
        for (int i = 0; i < N; i++) begin
            arb_bus.request_flatted_in[i*W +: W] = srcData[i];
        end
        @(posedge clk_in);
        #1;
    endtask

    // Grant id and data are only meaningful while the buffer is valid,
    // except right after reset where they must be zero.
    task automatic checkOutput(input string name, input logic exp_valid, input logic [L-1:0] exp_grant,
                               input logic [N-1:0] exp_ack, input logic [W-1:0] exp_data,
                               input logic full_check);
        vectorsApplied++;
        if (arb_bus.request_valid_out !== exp_valid) begin
            miscompares++;
            $display("[TB] FAIL %s request_valid_out got %0b expected %0b", name, arb_bus.request_valid_out, exp_valid);
        end
        if (arb_bus.issue_ack_out !== exp_ack) begin
            miscompares++;
            $display("[TB] FAIL %s issue_ack_out got %b expected %b", name, arb_bus.issue_ack_out, exp_ack);
        end
        if (exp_valid || full_check) begin
            if (arb_bus.grant_id_out !== exp_grant) begin
                miscompares++;
                $display("[TB] FAIL %s grant_id_out got %0d expected %0d", name, arb_bus.grant_id_out, exp_grant);
            end
            if (arb_bus.request_out !== exp_data) begin
                miscompares++;
                $display("[TB] FAIL %s request_out got %h expected %h", name, arb_bus.request_out, exp_data);
            end
        end
    endtask

    function automatic void addVec(input logic [N-1:0] valid, input logic ack_in, input logic exp_valid,
                                   input logic [L-1:0] exp_grant, input logic [N-1:0] exp_ack);
        vecs.push_back('{valid, ack_in, exp_valid, exp_grant, exp_ack});
    endfunction

    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        srcData[0] = 64'hA000_0000_0000_0A00;
        srcData[1] = 64'hB111_1111_1111_1B11;
        srcData[2] = 64'hC222_2222_2222_2C22;
        srcData[3] = 64'hD333_3333_3333_3D33;
        reset_in                         = 1'b1;
        arb_bus.request_flatted_in       = '0;
        arb_bus.request_valid_flatted_in = '0;
        arb_bus.issue_ack_in             = 1'b0;

        // Reset state
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, 2'd0, 4'b0000, 64'h0, 1'b1);

        // Fairness: all sources valid, downstream always accepts
        for (int k = 0; k < 16; k++) begin
            addVec(4'b1111, 1'b1, 1'b1, L'(k % N), N'(1 << (k % N)));
        end
        // Drain to empty
        addVec(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        // Back-to-back: sources 0 and 3, valid never drops between them
        addVec(4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001);
        addVec(4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000);
        addVec(4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000);
        addVec(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        // Empty drain from source 1, then a lone source-1 request again
        addVec(4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010);
        addVec(4'b0010, 1'b1, 1'b0, 2'd1, 4'b0000);
        addVec(4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
        addVec(4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010);
        // Downstream stall for 10 cycles holding source 1
        for (int k = 0; k < 10; k++) begin
            addVec(4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000);
        end
        // Accept: next in rotation (source 2) is captured
        addVec(4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100);
        addVec(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].ack_in, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_grant,
                        vecs[i].exp_ack, srcData[vecs[i].exp_grant], 1'b0);
        end

        // Single source FIFO 2 with two entries; one accept per two cycles
        srcData[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_a", 1'b1, 2'd2, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_b", 1'b0, 2'd2, 4'b0000, 64'h0, 1'b0);
        srcData[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_c", 1'b1, 2'd2, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_d", 1'b0, 2'd2, 4'b0000, 64'h0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("single_e", 1'b0, 2'd2, 4'b0000, 64'h0, 1'b0);

        // Reset while holding an unaccepted entry from source 1
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("rst_fill", 1'b1, 2'd1, 4'b0010, srcData[1], 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("rst_hold", 1'b1, 2'd1, 4'b0000, srcData[1], 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("rst_mid", 1'b0, 2'd0, 4'b0000, 64'h0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("rst_next", 1'b1, 2'd0, 4'b0001, srcData[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end
endmodule
